// File: rtl/tx_sequencer.sv
// RX/TX keying sequencer: mute, enable, ramp up, hold, ramp down, tail, with DAC-overflow trip.
// Optional TX_SEQ_HANG_EN adds a hang state that keeps TX keyed across short key gaps.
module tx_sequencer #(
    parameter int MUTE_TICKS = 50,
    parameter int RAMP_STEP  = 4,
    parameter int HANG_TICKS = 2000,
    parameter int TAIL_TICKS = 50,
    parameter int OF_TRIP    = 16
) (
    input  logic       clock_100k,
    input  logic       reset,
    input  logic       ptt,
    input  logic [7:0] tx_level_in,
    input  logic       dac_of,
    output logic       rx_mute,
    output logic       tx_enable,
    output logic [7:0] level_out,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0, MUTE = 3'd1, RAMP_UP = 3'd2, ON = 3'd3,
        HANG = 3'd4, RAMP_DOWN = 3'd5, TAIL = 3'd6
    } seq_state_t;

    generate
        if (MUTE_TICKS < 1 || MUTE_TICKS > 65535 || TAIL_TICKS < 1 || TAIL_TICKS > 65535 ||
            HANG_TICKS < 1 || HANG_TICKS > 65535 || OF_TRIP < 1 || OF_TRIP > 65535 ||
            RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_param_check
            $error("tx_sequencer: tick parameters must be 1..65535, RAMP_STEP 1..255");
        end
    endgenerate

    localparam logic [15:0] MUTE_LAST = 16'(MUTE_TICKS - 1);
    localparam logic [15:0] TAIL_LAST = 16'(TAIL_TICKS - 1);
    localparam logic [15:0] OF_LAST   = 16'(OF_TRIP - 1);
`ifdef TX_SEQ_HANG_EN
    localparam logic [15:0] HANG_LAST = 16'(HANG_TICKS - 1);
`endif
    localparam logic [7:0]  STEP8     = 8'(RAMP_STEP);

    seq_state_t  st, nxt;
    logic        ptt_meta, ptt_s;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] of_cnt, of_nxt;
    logic [7:0]  lvl_nxt, up_sat, dn;
    logic [8:0]  up9;
    logic        fault_nxt, of_active, trip;

    assign state = st;

    always_comb begin
        nxt       = st;
        lvl_nxt   = level_out;
        fault_nxt = fault;
        cnt_nxt   = cnt + 16'd1;
        of_nxt    = '0;
        trip      = 1'b0;
        // 9-bit sum so a step past 255 saturates to the target instead of wrapping
        up9       = {1'b0, level_out} + {1'b0, STEP8};
        up_sat    = (up9 > {1'b0, tx_level_in}) ? tx_level_in : up9[7:0];
        dn        = (level_out < STEP8) ? 8'd0 : level_out - STEP8;
        of_active = (st == RAMP_UP) || (st == ON) || (st == HANG);
        if (of_active && dac_of) begin
            of_nxt = of_cnt + 16'd1;
            trip   = (of_cnt == OF_LAST);
        end

        case (st)
            IDLE: begin
                lvl_nxt = '0;
                if (!ptt_s)      fault_nxt = 1'b0;
                else if (!fault) nxt = MUTE;
            end
            MUTE: begin
                if (!ptt_s)                nxt = TAIL;
                else if (cnt == MUTE_LAST) nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (trip) begin
                    fault_nxt = 1'b1;
                    nxt       = RAMP_DOWN;
                end else if (!ptt_s) begin
                    nxt = RAMP_DOWN;
                end else begin
                    lvl_nxt = up_sat;
                    if (up_sat == tx_level_in) nxt = ON;
                end
            end
            ON: begin
                lvl_nxt = tx_level_in;
                if (trip) begin
                    fault_nxt = 1'b1;
                    nxt       = RAMP_DOWN;
                end else if (!ptt_s) begin
`ifdef TX_SEQ_HANG_EN
                    nxt = HANG;
`else
                    nxt = RAMP_DOWN;
`endif
                end
            end
`ifdef TX_SEQ_HANG_EN
            HANG: begin
                if (trip) begin
                    fault_nxt = 1'b1;
                    nxt       = RAMP_DOWN;
                end else if (ptt_s) begin
                    nxt = ON;
                end else if (cnt == HANG_LAST) begin
                    nxt = RAMP_DOWN;
                end
            end
`endif
            RAMP_DOWN: begin
                // re-key reverses from the current level without re-muting
                if (ptt_s && !fault) begin
                    nxt = RAMP_UP;
                end else begin
                    lvl_nxt = dn;
                    if (dn == 8'd0) nxt = TAIL;
                end
            end
            TAIL: begin
                lvl_nxt = '0;
                if (ptt_s && !fault)       nxt = RAMP_UP;
                else if (cnt == TAIL_LAST) nxt = IDLE;
            end
            default: begin
                nxt     = IDLE;
                lvl_nxt = '0;
            end
        endcase

        if (nxt != st) cnt_nxt = '0;
    end

    always_ff @(posedge clock_100k) begin
        if (reset) begin
            st        <= IDLE;
            ptt_meta  <= 1'b0;
            ptt_s     <= 1'b0;
            cnt       <= '0;
            of_cnt    <= '0;
            level_out <= '0;
            fault     <= 1'b0;
            rx_mute   <= 1'b0;
            tx_enable <= 1'b0;
        end else begin
            st        <= nxt;
            ptt_meta  <= ptt;
            ptt_s     <= ptt_meta;
            cnt       <= cnt_nxt;
            of_cnt    <= of_nxt;
            level_out <= lvl_nxt;
            fault     <= fault_nxt;
            rx_mute   <= (nxt != IDLE);
            tx_enable <= (nxt == RAMP_UP) || (nxt == ON) || (nxt == HANG) || (nxt == RAMP_DOWN);
        end
    end

endmodule

// File: tb/tb_tx_sequencer.sv
// Directed bench for tx_sequencer; observation packs {state, rx_mute, tx_enable, fault, level_out}.
module tb_tx_sequencer;

    logic       clock_100k = 1'b0;
    logic       reset;
    logic       ptt;
    logic [7:0] tx_level_in;
    logic       dac_of;
    logic       rx_mute, tx_enable, fault;
    logic [7:0] level_out;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;
    logic [13:0] obs, exp_v;

    always #5 clock_100k = ~clock_100k;

    tx_sequencer dut (
        .clock_100k (clock_100k),
        .reset      (reset),
        .ptt        (ptt),
        .tx_level_in(tx_level_in),
        .dac_of     (dac_of),
        .rx_mute    (rx_mute),
        .tx_enable  (tx_enable),
        .level_out  (level_out),
        .fault      (fault),
        .state      (state)
    );

    assign obs = {state, rx_mute, tx_enable, fault, level_out};

    function automatic logic [13:0] pk(input int s, input int m, input int e, input int f, input int l);
        logic [31:0] sv, mv, ev, fv, lv;
        sv = s; mv = m; ev = e; fv = f; lv = l;
        return {sv[2:0], mv[0], ev[0], fv[0], lv[7:0]};
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_100k);
            #1;
        end
    endtask

    task automatic go_idle();
        ptt = 1'b0;
        cyc(110);
        exp_v = pk(0, 0, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL go_idle obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset();
        reset = 1'b1; ptt = 1'b1; tx_level_in = 8'd200; dac_of = 1'b0;
        cyc(3);
        exp_v = pk(0, 0, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_hold obs=%h exp=%h", obs, exp_v); end
        reset = 1'b0;
        cyc(2);
        exp_v = pk(0, 0, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sync_delay obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(1, 1, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mute_rise obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_keyup();
        cyc(49);
        exp_v = pk(1, 1, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mute_hold obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(2, 1, 1, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL tx_en_rise obs=%h exp=%h", obs, exp_v); end
        for (int k = 1; k <= 50; k++) begin
            cyc(1);
            exp_v = pk(k == 50 ? 3 : 2, 1, 1, 0, 4 * k); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL ramp_up k=%0d obs=%h exp=%h", k, obs, exp_v); end
        end
    endtask

`ifndef TX_SEQ_HANG_EN
    task automatic test_release();
        ptt = 1'b0;
        cyc(2);
        exp_v = pk(3, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL release_sync obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(5, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL release_rd obs=%h exp=%h", obs, exp_v); end
        for (int k = 1; k <= 50; k++) begin
            cyc(1);
            exp_v = pk(k == 50 ? 6 : 5, 1, k == 50 ? 0 : 1, 0, 200 - 4 * k); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL ramp_down k=%0d obs=%h exp=%h", k, obs, exp_v); end
        end
        cyc(49);
        exp_v = pk(6, 1, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL tail_hold obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(0, 0, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL tail_end obs=%h exp=%h", obs, exp_v); end
    endtask
`else
    task automatic test_hang();
        ptt = 1'b0;
        cyc(3);
        exp_v = pk(4, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL hang_enter obs=%h exp=%h", obs, exp_v); end
        cyc(997);
        ptt = 1'b1;
        cyc(2);
        exp_v = pk(4, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL hang_gap obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(3, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL hang_rekey obs=%h exp=%h", obs, exp_v); end
        ptt = 1'b0;
        cyc(3 + 1999);
        exp_v = pk(4, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL hang_long obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(5, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL hang_expire obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(5, 1, 1, 0, 196); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL hang_rd obs=%h exp=%h", obs, exp_v); end
        cyc(100);
        exp_v = pk(0, 0, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL hang_idle obs=%h exp=%h", obs, exp_v); end
    endtask
`endif

    task automatic test_reversal();
        tx_level_in = 8'd200; ptt = 1'b1;
        cyc(76);
        exp_v = pk(2, 1, 1, 0, 92); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rev_ramp obs=%h exp=%h", obs, exp_v); end
        ptt = 1'b0;
        cyc(2);
        exp_v = pk(2, 1, 1, 0, 100); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rev_peak obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(5, 1, 1, 0, 100); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rev_down obs=%h exp=%h", obs, exp_v); end
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            exp_v = pk(5, 1, 1, 0, 100 - 4 * k); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL rev_fall k=%0d obs=%h exp=%h", k, obs, exp_v); end
        end
        ptt = 1'b1;
        cyc(2);
        exp_v = pk(5, 1, 1, 0, 60); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rev_low obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(2, 1, 1, 0, 60); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rev_up obs=%h exp=%h", obs, exp_v); end
        for (int k = 1; k <= 35; k++) begin
            cyc(1);
            exp_v = pk(k == 35 ? 3 : 2, 1, 1, 0, 60 + 4 * k); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL rev_rise k=%0d obs=%h exp=%h", k, obs, exp_v); end
        end
    endtask

    task automatic test_overflow();
        dac_of = 1'b1;
        cyc(15);
        dac_of = 1'b0;
        cyc(1);
        exp_v = pk(3, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_burst15 obs=%h exp=%h", obs, exp_v); end
        dac_of = 1'b1;
        cyc(15);
        exp_v = pk(3, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_pre_trip obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(5, 1, 1, 1, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_trip obs=%h exp=%h", obs, exp_v); end
        dac_of = 1'b0;
        cyc(50);
        exp_v = pk(6, 1, 0, 1, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_tail obs=%h exp=%h", obs, exp_v); end
        cyc(50);
        exp_v = pk(0, 0, 0, 1, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_idle obs=%h exp=%h", obs, exp_v); end
        cyc(10);
        exp_v = pk(0, 0, 0, 1, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_lockout obs=%h exp=%h", obs, exp_v); end
        ptt = 1'b0;
        cyc(2);
        exp_v = pk(0, 0, 0, 1, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_clr_wait obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(0, 0, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_clear obs=%h exp=%h", obs, exp_v); end
        ptt = 1'b1;
        cyc(3);
        exp_v = pk(1, 1, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_restart obs=%h exp=%h", obs, exp_v); end
        cyc(100);
        exp_v = pk(3, 1, 1, 0, 200); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL of_reon obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_clamp();
        tx_level_in = 8'd200; ptt = 1'b1;
        cyc(63);
        exp_v = pk(2, 1, 1, 0, 40); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clamp_pre obs=%h exp=%h", obs, exp_v); end
        tx_level_in = 8'd30;
        cyc(1);
        exp_v = pk(3, 1, 1, 0, 30); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clamp_30 obs=%h exp=%h", obs, exp_v); end
        tx_level_in = 8'd255;
        cyc(1);
        exp_v = pk(3, 1, 1, 0, 255); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL track_255 obs=%h exp=%h", obs, exp_v); end
        tx_level_in = 8'd17;
        cyc(1);
        exp_v = pk(3, 1, 1, 0, 17); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL track_17 obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_zero_level();
        tx_level_in = 8'd0; ptt = 1'b1;
        cyc(53);
        exp_v = pk(2, 1, 1, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL zero_rampup obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(3, 1, 1, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL zero_on obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_mute_abort();
        tx_level_in = 8'd200; ptt = 1'b1;
        cyc(10);
        ptt = 1'b0;
        cyc(2);
        exp_v = pk(1, 1, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL abort_mute obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(6, 1, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL abort_tail obs=%h exp=%h", obs, exp_v); end
        cyc(50);
        exp_v = pk(0, 0, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL abort_idle obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_tail_rekey();
        tx_level_in = 8'd8; ptt = 1'b1;
        cyc(55);
        exp_v = pk(3, 1, 1, 0, 8); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rekey_on obs=%h exp=%h", obs, exp_v); end
        ptt = 1'b0;
        cyc(5);
        exp_v = pk(6, 1, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rekey_tail obs=%h exp=%h", obs, exp_v); end
        ptt = 1'b1;
        cyc(2);
        exp_v = pk(6, 1, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rekey_wait obs=%h exp=%h", obs, exp_v); end
        cyc(1);
        exp_v = pk(2, 1, 1, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rekey_skip_mute obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        cyc(2);
        exp_v = pk(3, 1, 1, 0, 8); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mid_on obs=%h exp=%h", obs, exp_v); end
        reset = 1'b1;
        cyc(1);
        exp_v = pk(0, 0, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mid_reset obs=%h exp=%h", obs, exp_v); end
        ptt = 1'b0;
        cyc(1);
        reset = 1'b0;
        cyc(5);
        exp_v = pk(0, 0, 0, 0, 0); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mid_after obs=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_keyup();
`ifndef TX_SEQ_HANG_EN
        test_release();
`else
        test_hang();
`endif
        test_reversal();
        test_overflow();
        go_idle();
        test_clamp();
        go_idle();
        test_zero_level();
        go_idle();
        test_mute_abort();
        test_tail_rekey();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_sequencer.md
# tx_sequencer

Receive/transmit keying sequencer for the transceiver. It takes the CW/PTT key request and the I2C-programmed `tx_level`, and drives the RX mute, the transmitter enable and a ramped level for the power PWM. Every RX→TX and TX→RX changeover is therefore click-free and follows a fixed order: mute, enable, ramp up, hold, ramp down, tail. It also trips the transmitter off when DAC overflow persists. It runs in the `clock_100k` domain next to `reset`, `clip_led` and `clkgen_init`.

## Interface
- `MUTE_TICKS`, 50: cycles RX is muted before TX enable (0.5 ms).
- `RAMP_STEP`, 4: level change per cycle during ramps.
- `HANG_TICKS`, 2000: TX hang after key release (20 ms). Used only with `TX_SEQ_HANG_EN`.
- `TAIL_TICKS`, 50: cycles RX stays muted after TX disable.
- `OF_TRIP`, 16: consecutive `dac_of` cycles that trip a fault.

Ports:
- `clock_100k` in 1: 100 kHz system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ptt` in 1: asynchronous key request (CW pin OR I2C PTT bit).
- `tx_level_in` in 8: target power level from `i2c_control`.
- `dac_of` in 1: DAC overflow flag from the transmitter.
- `rx_mute` out 1: mutes receiver audio to I2S.
- `tx_enable` out 1: enables the transmitter datapath.
- `level_out` out 8: ramped level feeding the PWM comparator.
- `fault` out 1: overflow trip flag.
- `state` out 3: current FSM state, for test pins/debug.

## Operation
- `ptt` passes through a two-flop synchronizer; `ptt_s` is the second flop. FSM decisions use `ptt_s` only.
- State encodings: IDLE=0, MUTE=1, RAMP_UP=2, ON=3, HANG=4, RAMP_DOWN=5, TAIL=6.
- IDLE: `rx_mute`=0, `tx_enable`=0, `level_out`=0. `ptt_s`=1 and no lockout → MUTE, counter cleared.
- MUTE: `rx_mute`=1 for exactly `MUTE_TICKS` cycles, then RAMP_UP. `ptt_s`=0 during MUTE → TAIL.
- RAMP_UP: `tx_enable`=1. Each cycle `level_out` ← min(`level_out`+`RAMP_STEP`, `tx_level_in`), computed 9-bit and saturated. When `level_out` equals the target → ON. `ptt_s`=0 → RAMP_DOWN from the current level.
- ON: `level_out` tracks `tx_level_in` each cycle, no ramp. `ptt_s`=0 → HANG if the macro is defined, else RAMP_DOWN.
- HANG: level is held. `ptt_s`=1 → ON and the counter is cleared. After `HANG_TICKS` cycles with `ptt_s`=0 → RAMP_DOWN.
- RAMP_DOWN: each cycle `level_out` ← max(`level_out`−`RAMP_STEP`, 0). At 0 → TAIL. `ptt_s`=1 and no fault → RAMP_UP from the current level.
- TAIL: `tx_enable`=0, `rx_mute`=1 for `TAIL_TICKS` cycles, then IDLE. `ptt_s`=1 and no fault → RAMP_UP, skipping MUTE because RX is still muted.
- Overflow trip:
  - An `of_cnt` counter counts consecutive `dac_of`=1 cycles in RAMP_UP, ON or HANG, and clears on any `dac_of`=0.
  - Reaching `OF_TRIP` sets `fault`=1 and forces RAMP_DOWN.
  - While `fault`=1, `ptt_s` re-assertion is ignored, and IDLE does not leave.
  - `fault` clears in IDLE on the first cycle with `ptt_s`=0.
- Counters are 16 bits. Parameters must fit in 16 bits.

## Timing
- Reset values: state IDLE, `rx_mute`=0, `tx_enable`=0, `level_out`=0, `fault`=0, counters 0, synchronizer flops 0.
- All outputs are registered and change one cycle after the state/counter condition.
- `ptt` rising edge to `rx_mute`=1: 3 cycles (2 sync + 1 FSM).
- `rx_mute`=1 to `tx_enable`=1: `MUTE_TICKS` cycles.
- `tx_level_in` change while in ON: seen on `level_out` 1 cycle later.
- `tx_level_in` lowered below `level_out` during RAMP_UP: `level_out` clamps to the new value next cycle, then ON.
- `tx_level_in`=0: RAMP_UP lasts 1 cycle, then ON at level 0.
- `reset` mid-transmission: all outputs go to reset values on the next edge, with no ramp-down.

## Configuration
- `TX_SEQ_HANG_EN` defined: the HANG state exists (semi-break-in CW). Key gaps shorter than `HANG_TICKS` keep TX keyed at full level.
- Not defined: HANG logic and its counter are removed; ON goes directly to RAMP_DOWN on release. `HANG_TICKS` is ignored.

## Test plan
- Reset defaults: `tx_level_in`=200, `ptt`=1 held through reset → after reset release, `rx_mute` rises 3 cycles later; `tx_enable` rises 50 cycles after that; `level_out` steps 4,8,…,200 over 50 cycles; `state`=3.
- Release without hang: `ptt`=0 in ON → `level_out` falls 200→0 over 50 cycles; `tx_enable` drops; `rx_mute` drops 50 cycles later; `state`=0.
- Hang (macro defined): `ptt` released for 1000 cycles then re-asserted → `level_out` stays 200 and state returns 3. A 2500-cycle release → RAMP_DOWN starts after 2000 cycles.
- Mid-ramp reversal: `ptt` drops when `level_out`=100 → ramp down from 100. Re-asserting at 60 → ramp up from 60 to 200, with no MUTE re-entry.
- Overflow trip: `dac_of`=1 for 15 cycles, then 0, then 16 cycles in ON → no trip on the first burst. On the second, `fault`=1, ramp down to IDLE, and `ptt`=1 is ignored. `ptt`=0 then 1 → `fault` clears and a normal sequence restarts.
- Level tracking and clamp: in RAMP_UP at `level_out`=40, set `tx_level_in`=30 → `level_out`=30 next cycle, then ON. In ON, set `tx_level_in`=255 → `level_out`=255 one cycle later.
